// File: rtl/except_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : except_pipe_tracker
// Brief    : Picks one exception cause per instruction, carries it through
//            DEPTH stages to commit, then holds a valid/ready trap request.
//            Build option: EXC_TVAL_INST_EN puts the instruction word in the
//            tval of an illegal-instruction trap.
// Revision : 1.0 - initial release
// ============================================================================
module except_pipe_tracker #(
  parameter int XLEN  = 64,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [31:0]          inst_i,
  input  logic [1:0]           priv_i,
  input  logic [NSRC-1:0]      src_vld_i,
  input  logic [NSRC*XLEN-1:0] src_cause_i,
  input  logic [NSRC*XLEN-1:0] src_tval_i,
  input  logic                 illegal_i,
  input  logic                 ebreak_i,
  input  logic                 ecall_i,
  input  logic                 trap_ready_i,
  output logic                 trap_valid_o,
  output logic [XLEN-1:0]      trap_epc_o,
  output logic [XLEN-1:0]      trap_cause_o,
  output logic [XLEN-1:0]      trap_tval_o,
  output logic                 kill_o,
  output logic                 busy_o
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d, exc_q, exc_d;
  logic [XLEN-1:0]  epc_q   [DEPTH];
  logic [XLEN-1:0]  epc_d   [DEPTH];
  logic [XLEN-1:0]  cause_q [DEPTH];
  logic [XLEN-1:0]  cause_d [DEPTH];
  logic [XLEN-1:0]  tval_q  [DEPTH];
  logic [XLEN-1:0]  tval_d  [DEPTH];
  logic             trap_valid_q, trap_valid_d, kill_q, kill_d;
  logic [XLEN-1:0]  trap_epc_q, trap_epc_d, trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]  trap_tval_q, trap_tval_d;

  logic             sel_exc;
  logic [XLEN-1:0]  sel_cause, sel_tval, ill_tval;
  logic             head_exc;

`ifdef EXC_TVAL_INST_EN
  assign ill_tval = XLEN'(inst_i);
`else
  logic unused_inst;
  assign unused_inst = ^inst_i;
  assign ill_tval    = '0;
`endif

  // Lowest-priority sources are applied first so higher ones overwrite them.
  always_comb begin
    sel_exc   = 1'b0;
    sel_cause = '0;
    sel_tval  = '0;
    if (in_valid_i) begin
      if (ecall_i) begin
        sel_exc   = 1'b1;
        sel_cause = XLEN'(4'd8 + {2'b00, priv_i});
        sel_tval  = '0;
      end
      if (ebreak_i) begin
        sel_exc   = 1'b1;
        sel_cause = XLEN'(3);
        sel_tval  = '0;
      end
      if (illegal_i) begin
        sel_exc   = 1'b1;
        sel_cause = XLEN'(2);
        sel_tval  = ill_tval;
      end
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (src_vld_i[i]) begin
          sel_exc   = 1'b1;
          sel_cause = src_cause_i[i*XLEN +: XLEN];
          sel_tval  = src_tval_i[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign head_exc = valid_q[DEPTH-1] & exc_q[DEPTH-1];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    exc_d        = exc_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    tval_d       = tval_q;
    trap_valid_d = trap_valid_q;
    kill_d       = kill_q;
    trap_epc_d   = trap_epc_q;
    trap_cause_d = trap_cause_q;
    trap_tval_d  = trap_tval_q;
    case (state_q)
      ST_RUN: begin
        if (flush_i) begin
          valid_d = '0;
          exc_d   = '0;
        end else if (head_exc) begin
          // The oldest exception has committed; freeze the pipe behind it.
          state_d      = ST_TRAP;
          trap_valid_d = 1'b1;
          kill_d       = 1'b1;
          trap_epc_d   = epc_q[DEPTH-1];
          trap_cause_d = cause_q[DEPTH-1];
          trap_tval_d  = tval_q[DEPTH-1];
        end else if (!stall_i) begin
          valid_d[0] = in_valid_i;
          exc_d[0]   = sel_exc;
          epc_d[0]   = pc_i;
          cause_d[0] = sel_cause;
          tval_d[0]  = sel_tval;
          for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            exc_d[k]   = exc_q[k-1];
            epc_d[k]   = epc_q[k-1];
            cause_d[k] = cause_q[k-1];
            tval_d[k]  = tval_q[k-1];
          end
        end
      end
      ST_TRAP: begin
        if (trap_valid_q && trap_ready_i) begin
          state_d      = ST_RUN;
          valid_d      = '0;
          exc_d        = '0;
          trap_valid_d = 1'b0;
          kill_d       = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      valid_q      <= '0;
      exc_q        <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        epc_q[k]   <= '0;
        cause_q[k] <= '0;
        tval_q[k]  <= '0;
      end
      trap_valid_q <= 1'b0;
      kill_q       <= 1'b0;
      trap_epc_q   <= '0;
      trap_cause_q <= '0;
      trap_tval_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      exc_q        <= exc_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      tval_q       <= tval_d;
      trap_valid_q <= trap_valid_d;
      kill_q       <= kill_d;
      trap_epc_q   <= trap_epc_d;
      trap_cause_q <= trap_cause_d;
      trap_tval_q  <= trap_tval_d;
    end
  end

  assign trap_valid_o = trap_valid_q;
  assign trap_epc_o   = trap_epc_q;
  assign trap_cause_o = trap_cause_q;
  assign trap_tval_o  = trap_tval_q;
  assign kill_o       = kill_q;
  assign busy_o       = |(valid_q & exc_q);

endmodule
`default_nettype wire

// File: tb/tb_except_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_except_pipe_tracker
// Brief    : Directed vector table plus multi-cycle sequences for the
//            exception pipeline tracker (XLEN=64, NSRC=2, DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_except_pipe_tracker;

`ifdef EXC_TVAL_INST_EN
  localparam bit c_inst_en = 1'b1;
`else
  localparam bit c_inst_en = 1'b0;
`endif
  localparam logic [63:0] c_cause0 = 64'h1;
  localparam logic [63:0] c_cause1 = 64'h4;
  localparam logic [63:0] c_tval0  = 64'hDEAD_0000;
  localparam logic [63:0] c_tval1  = 64'hBEEF_0000;

  logic         clk = 1'b0;
  logic         rst, stall_i, flush_i, in_valid_i;
  logic [63:0]  pc_i;
  logic [31:0]  inst_i;
  logic [1:0]   priv_i, src_vld_i;
  logic [127:0] src_cause_i, src_tval_i;
  logic         illegal_i, ebreak_i, ecall_i, trap_ready_i;
  logic         trap_valid_o, kill_o, busy_o;
  logic [63:0]  trap_epc_o, trap_cause_o, trap_tval_o;

  int n_tests = 0;
  int n_fail  = 0;

  except_pipe_tracker #(.XLEN(64), .NSRC(2), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .pc_i(pc_i), .inst_i(inst_i), .priv_i(priv_i),
    .src_vld_i(src_vld_i), .src_cause_i(src_cause_i), .src_tval_i(src_tval_i),
    .illegal_i(illegal_i), .ebreak_i(ebreak_i), .ecall_i(ecall_i),
    .trap_ready_i(trap_ready_i), .trap_valid_o(trap_valid_o),
    .trap_epc_o(trap_epc_o), .trap_cause_o(trap_cause_o),
    .trap_tval_o(trap_tval_o), .kill_o(kill_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src_vld;
    logic        ill;
    logic        ebr;
    logic        ecl;
    logic [1:0]  priv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        trap;
    logic [63:0] cause;
    logic [63:0] tval;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid_i = 1'b1;
    src_vld_i  = v.src_vld;
    illegal_i  = v.ill;
    ebreak_i   = v.ebr;
    ecall_i    = v.ecl;
    priv_i     = v.priv;
    pc_i       = v.pc;
    inst_i     = v.inst;
  endtask

  task automatic idle_in();
    in_valid_i = 1'b0;
    src_vld_i  = 2'b00;
    illegal_i  = 1'b0;
    ebreak_i   = 1'b0;
    ecall_i    = 1'b0;
  endtask

  // Counts edges until trap_valid_o rises, bounded at 12.
  task automatic wait_trap(inout int lat);
    while (!trap_valid_o && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    trap_ready_i = 1'b1;
    tick();
    trap_ready_i = 1'b0;
  endtask

  function automatic vec_t mk_ill(input logic [63:0] pc);
    vec_t v;
    v = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd3, pc, 32'hFFFF_FFFF, 1'b1, 64'd2,
          c_inst_en ? 64'hFFFF_FFFF : 64'h0};
    return v;
  endfunction

  initial begin
    int lat;
    vec_t v;
    vecs[0] = mk_ill(64'h8000_0010);
    vecs[1] = '{2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 64'h1000, 32'h73, 1'b1, 64'd8,  64'h0};
    vecs[2] = '{2'b00, 1'b0, 1'b0, 1'b1, 2'd1, 64'h1004, 32'h73, 1'b1, 64'd9,  64'h0};
    vecs[3] = '{2'b00, 1'b0, 1'b0, 1'b1, 2'd3, 64'h1008, 32'h73, 1'b1, 64'd11, 64'h0};
    vecs[4] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'd3, 64'h2000, 32'h1234_5678, 1'b1, c_cause0, c_tval0};
    vecs[5] = '{2'b10, 1'b1, 1'b1, 1'b1, 2'd3, 64'h2004, 32'h1234_5678, 1'b1, c_cause1, c_tval1};
    vecs[6] = '{2'b00, 1'b0, 1'b1, 1'b1, 2'd3, 64'h3000, 32'h0010_0073, 1'b1, 64'd3, 64'h0};
    vecs[7] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'd3, 64'h3004, 32'h0000_0013, 1'b0, 64'd0, 64'h0};
    vecs[8] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'd0, 64'h3008, 32'h1234_5678, 1'b1, 64'd2,
                c_inst_en ? 64'h1234_5678 : 64'h0};

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; trap_ready_i = 1'b0;
    pc_i = '0; inst_i = '0; priv_i = '0;
    src_cause_i = {c_cause1, c_cause0};
    src_tval_i  = {c_tval1, c_tval0};
    idle_in();
    tick(); tick();
    chk("rst_trap_valid", 64'(trap_valid_o), 64'd0);
    chk("rst_kill", 64'(kill_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cause", trap_cause_o, 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      idle_in();
      lat = 0;
      chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(vecs[i].trap));
      wait_trap(lat);
      if (vecs[i].trap) begin
        chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
        chk($sformatf("v%0d_epc", i), trap_epc_o, vecs[i].pc);
        chk($sformatf("v%0d_cause", i), trap_cause_o, vecs[i].cause);
        chk($sformatf("v%0d_tval", i), trap_tval_o, vecs[i].tval);
        chk($sformatf("v%0d_kill", i), 64'(kill_o), 64'd1);
        handshake();
        chk($sformatf("v%0d_post_valid", i), 64'(trap_valid_o), 64'd0);
        chk($sformatf("v%0d_post_busy", i), 64'(busy_o), 64'd0);
      end else begin
        chk($sformatf("v%0d_no_trap", i), 64'(trap_valid_o), 64'd0);
      end
      tick();
    end

    // Two stall cycles in flight stretch latency to 5; then hold ready low.
    drive(mk_ill(64'h4000));
    tick();
    idle_in();
    stall_i = 1'b1;
    tick(); tick();
    stall_i = 1'b0;
    lat = 2;
    wait_trap(lat);
    chk("stall_latency", 64'(lat), 64'd5);
    v = mk_ill(64'h4100);
    v.ill = 1'b0; v.ecl = 1'b1;
    for (int c = 0; c < 5; c++) begin
      flush_i = (c == 1);
      stall_i = (c == 2);
      if (c == 3) drive(v);
      else idle_in();
      tick();
      chk($sformatf("hold%0d_valid", c), 64'(trap_valid_o), 64'd1);
      chk($sformatf("hold%0d_epc", c), trap_epc_o, 64'h4000);
      chk($sformatf("hold%0d_kill", c), 64'(kill_o), 64'd1);
    end
    flush_i = 1'b0; stall_i = 1'b0; idle_in();
    chk("hold_busy", 64'(busy_o), 64'd1);
    handshake();
    chk("hold_post_valid", 64'(trap_valid_o), 64'd0);
    chk("hold_post_kill", 64'(kill_o), 64'd0);
    chk("hold_post_busy", 64'(busy_o), 64'd0);
    tick();

    // Back-to-back: older illegal reported, younger ecall dropped.
    drive(mk_ill(64'h5000));
    tick();
    v = mk_ill(64'h5004);
    v.ill = 1'b0; v.ecl = 1'b1;
    drive(v);
    tick();
    idle_in();
    lat = 1;
    wait_trap(lat);
    chk("b2b_latency", 64'(lat), 64'd3);
    chk("b2b_epc", trap_epc_o, 64'h5000);
    chk("b2b_cause", trap_cause_o, 64'd2);
    handshake();
    lat = 0;
    wait_trap(lat);
    chk("b2b_younger_dropped", 64'(trap_valid_o), 64'd0);
    chk("b2b_busy", 64'(busy_o), 64'd0);

    // Flush in RUN kills the in-flight exception.
    drive(mk_ill(64'h6000));
    tick();
    idle_in();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'd0);
    lat = 0;
    wait_trap(lat);
    chk("flush_no_trap", 64'(trap_valid_o), 64'd0);

    // Reset while in TRAP drops the request.
    drive(mk_ill(64'h7000));
    tick();
    idle_in();
    lat = 0;
    wait_trap(lat);
    chk("rtrap_valid", 64'(trap_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rtrap_post_valid", 64'(trap_valid_o), 64'd0);
    chk("rtrap_post_kill", 64'(kill_o), 64'd0);
    chk("rtrap_post_busy", 64'(busy_o), 64'd0);
    chk("rtrap_post_epc", trap_epc_o, 64'd0);
    tick();
    chk("rtrap_stays_idle", 64'(trap_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
